// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
//   Shared definitions for the TPU job sequencer:
//     - default parameter values (operand width, accumulator width, array
//       size, drain length)
//     - sequencer FSM state encoding
//     - lane / matrix-element bit-offset helpers used to pack and unpack the
//       flat matrix and lane buses
// -----------------------------------------------------------------------------
package tpu_pkg;

    localparam int DEF_BIT_WIDTH    = 16;
    localparam int DEF_ACC_WIDTH    = 40;
    localparam int DEF_DEPTH        = 4;
    localparam int DEF_DRAIN_CYCLES = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_WT = 3'd1,
        SETTLE  = 3'd2,
        FEED    = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } tpu_state_e;

    // LSB of matrix element (r,c) in a row-major flat bus.
    function automatic int elem_lsb(input int r, input int c, input int depth, input int width);
        return (r * depth + c) * width;
    endfunction

    // LSB of lane i in a flat lane bus.
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tpu_skew_feed.sv
// -----------------------------------------------------------------------------
// tpu_skew_feed
//   Combinational diagonal skew selector. In feed step t, lane i carries
//   data element (i, t-i) when 0 <= t-i < DEPTH, otherwise zero, so the
//   array sees a wavefront that enters row i one cycle after row i-1.
//   Ports:
//     en_i        - selector enable; all lanes are zero when low
//     t_i         - feed step index
//     data_mat_i  - flat row-major data matrix
//     lanes_o     - skewed lane bus, lane i at [i*BIT_WIDTH +: BIT_WIDTH]
// -----------------------------------------------------------------------------
module tpu_skew_feed
    import tpu_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = 4
) (
    input  logic                               en_i,
    input  logic [CNT_W-1:0]                   t_i,
    input  logic [BIT_WIDTH*DEPTH*DEPTH-1:0]   data_mat_i,
    output logic [BIT_WIDTH*DEPTH-1:0]         lanes_o
);

    always_comb begin
        lanes_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (en_i && (int'(t_i) >= i) && (int'(t_i) - i < DEPTH)) begin
                lanes_o[lane_lsb(i, BIT_WIDTH) +: BIT_WIDTH] =
                    data_mat_i[elem_lsb(i, int'(t_i) - i, DEPTH, BIT_WIDTH) +: BIT_WIDTH];
            end
        end
    end

endmodule

// File: rtl/tpu_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_sequencer
//   Runs one weight-load / compute job on a DEPTH x DEPTH systolic array:
//   load weight rows bottom-up, settle one cycle, stream skewed data,
//   wait DRAIN_CYCLES for the wavefront to reach the bottom row, then
//   capture the bottom-row accumulators and pulse done.
//   Ports:
//     clk, rst     - clock, synchronous active-high reset
//     start        - job request (see handshake note below)
//     wt_mat       - flat weight matrix, element (r,c) at (r*DEPTH+c)*BIT_WIDTH
//     data_mat     - flat data matrix, same packing
//     pe_out       - bottom-row accumulators, lane j at j*ACC_WIDTH
//     control      - array weight-load enable
//     wt_arr       - weight bus to the array
//     data_arr     - skewed data bus to the array
//     busy         - job in progress (low in IDLE and DONE)
//     done         - one-cycle pulse when result is valid
//     result       - pe_out captured at the end of the last job
//     dbg_state_o  - current FSM state
// Handshake: start is a level sampled only in IDLE; a high start on any
//   clock edge in IDLE accepts one job. It is ignored in every other state,
//   so a requester holding start high gets back-to-back jobs separated by
//   one IDLE cycle. wt_mat/data_mat are read live and must stay stable
//   while busy.
// All outputs are registered: they are computed from the next state and
//   next counter value so they line up with the state they belong to.
// -----------------------------------------------------------------------------
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [BIT_WIDTH*DEPTH*DEPTH-1:0]  wt_mat,
    input  logic [BIT_WIDTH*DEPTH*DEPTH-1:0]  data_mat,
    input  logic [ACC_WIDTH*DEPTH-1:0]        pe_out,
    output logic                              control,
    output logic [BIT_WIDTH*DEPTH-1:0]        wt_arr,
    output logic [BIT_WIDTH*DEPTH-1:0]        data_arr,
    output logic                              busy,
    output logic                              done,
    output logic [ACC_WIDTH*DEPTH-1:0]        result,
    output tpu_state_e                        dbg_state_o
);

    // One counter is shared by every timed state, so it must hold the
    // longest phase length.
    localparam int CNT_MAX = max3(DEPTH, 2 * DEPTH - 1, DRAIN_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t LOAD_LAST  = cnt_t'(DEPTH - 1);
    localparam cnt_t FEED_LAST  = cnt_t'(2 * DEPTH - 2);
    localparam cnt_t DRAIN_LAST = cnt_t'(DRAIN_CYCLES - 1);

    tpu_state_e                    state_q, state_d;
    cnt_t                          cnt_q, cnt_d;
    logic                          capture;

    logic                          control_q, control_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [BIT_WIDTH*DEPTH-1:0]    wt_arr_q, wt_arr_d;
    logic [BIT_WIDTH*DEPTH-1:0]    data_arr_q, data_arr_d;
    logic [ACC_WIDTH*DEPTH-1:0]    result_q;

    // Next state and counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_WT;
                    cnt_d   = '0;
                end
            end
            LOAD_WT: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Skewed data for the upcoming FEED step.
    tpu_skew_feed #(
        .BIT_WIDTH (BIT_WIDTH),
        .DEPTH     (DEPTH),
        .CNT_W     (CNT_W)
    ) u_skew (
        .en_i       (state_d == FEED),
        .t_i        (cnt_d),
        .data_mat_i (data_mat),
        .lanes_o    (data_arr_d)
    );

    // Registered-output values for the upcoming cycle. Weight rows go out
    // bottom row first so the top row ends up nearest the array input.
    always_comb begin
        control_d = (state_d == LOAD_WT);
        busy_d    = (state_d != IDLE) && (state_d != DONE);
        done_d    = (state_d == DONE);
        wt_arr_d  = '0;
        if (state_d == LOAD_WT) begin
            for (int j = 0; j < DEPTH; j++) begin
                wt_arr_d[lane_lsb(j, BIT_WIDTH) +: BIT_WIDTH] =
                    wt_mat[elem_lsb(DEPTH - 1 - int'(cnt_d), j, DEPTH, BIT_WIDTH) +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            control_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wt_arr_q   <= '0;
            data_arr_q <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            control_q  <= control_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wt_arr_q   <= wt_arr_d;
            data_arr_q <= data_arr_d;
            if (capture) begin
                result_q <= pe_out;
            end
        end
    end

    assign control     = control_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wt_arr      = wt_arr_q;
    assign data_arr    = data_arr_q;
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tpu_sequencer
//   Directed bench for tpu_sequencer with default parameters.
// -----------------------------------------------------------------------------
module tb_tpu_sequencer;
  import tpu_pkg::*;

  localparam int BW = 16;
  localparam int AW = 40;
  localparam int D  = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [BW*D*D-1:0] wt_mat;
  logic [BW*D*D-1:0] data_mat;
  logic [AW*D-1:0]   pe_out;
  logic              control;
  logic [BW*D-1:0]   wt_arr;
  logic [BW*D-1:0]   data_arr;
  logic              busy;
  logic              done;
  logic [AW*D-1:0]   result;
  tpu_state_e        dbg_state;

  always #5 clk = ~clk;

  tpu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .wt_mat      (wt_mat),
    .data_mat    (data_mat),
    .pe_out      (pe_out),
    .control     (control),
    .wt_arr      (wt_arr),
    .data_arr    (data_arr),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .dbg_state_o (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected buses for identity weights and data(r,c)=4r+c.
  logic [63:0] wt_exp [4] = '{64'h0001_0000_0000_0000, 64'h0000_0001_0000_0000,
                              64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001};
  logic [63:0] data_exp [7] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0004_0001,
                                64'h0000_0008_0005_0002, 64'h000c_0009_0006_0003,
                                64'h000d_000a_0007_0000, 64'h000e_000b_0000_0000,
                                64'h000f_0000_0000_0000};

  // ---------------------------------------------------------------- drivers
  // Raise start at a negedge, let it be sampled on edge E0, then drop it.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_state"},    160'(dbg_state), 160'(IDLE));
    check_val({tag, "_control"},  160'(control),   160'(0));
    check_val({tag, "_wt_arr"},   160'(wt_arr),    160'(0));
    check_val({tag, "_data_arr"}, 160'(data_arr),  160'(0));
    check_val({tag, "_busy"},     160'(busy),      160'(0));
    check_val({tag, "_done"},     160'(done),      160'(0));
    check_val({tag, "_result"},   160'(result),    160'(0));
  endtask

  // Expected outputs of the reference job in cycle c after E0.
  task automatic check_ref_cycle(input int c, input logic [159:0] old_res, input logic [159:0] new_res);
    tpu_state_e  e_state;
    logic        e_ctrl, e_busy, e_done;
    logic [63:0] e_wt, e_data;
    logic [159:0] e_res;
    e_ctrl = 1'b0; e_busy = 1'b1; e_done = 1'b0;
    e_wt = '0; e_data = '0; e_res = old_res;
    if (c <= 3) begin
      e_state = LOAD_WT; e_ctrl = 1'b1; e_wt = wt_exp[c];
    end else if (c == 4) begin
      e_state = SETTLE;
    end else if (c <= 11) begin
      e_state = FEED; e_data = data_exp[c-5];
    end else if (c <= 19) begin
      e_state = DRAIN;
    end else if (c == 20) begin
      e_state = DONE; e_busy = 1'b0; e_done = 1'b1; e_res = new_res;
    end else begin
      e_state = IDLE; e_busy = 1'b0; e_res = new_res;
    end
    check_val($sformatf("c%0d_state", c),    160'(dbg_state), 160'(e_state));
    check_val($sformatf("c%0d_control", c),  160'(control),   160'(e_ctrl));
    check_val($sformatf("c%0d_wt_arr", c),   160'(wt_arr),    160'(e_wt));
    check_val($sformatf("c%0d_data_arr", c), 160'(data_arr),  160'(e_data));
    check_val($sformatf("c%0d_busy", c),     160'(busy),      160'(e_busy));
    check_val($sformatf("c%0d_done", c),     160'(done),      160'(e_done));
    check_val($sformatf("c%0d_result", c),   160'(result),    e_res);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [159:0] res1, res2, res3;
  int done_cnt;
  int done_at;

  initial begin
    rst = 1'b1; start = 1'b1;
    wt_mat = '0; data_mat = '0; pe_out = '0;
    for (int r = 0; r < D; r++) begin
      for (int c = 0; c < D; c++) begin
        if (r == c) wt_mat[(r*D+c)*BW +: BW] = 16'd1;
        data_mat[(r*D+c)*BW +: BW] = 16'(4*r + c);
      end
    end
    res1 = {40'h12345, 40'h3, 40'h2, 40'h1};
    res2 = {40'hAA_0000_0001, 40'hBB, 40'hCC, 40'hDD};
    res3 = {40'h5, 40'h6, 40'h7, 40'h8};

    // Reset overrides a high start.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0; start = 1'b0;

    // Reference job: full cycle-by-cycle check.
    pe_out = res1;
    pulse_start();
    for (int c = 0; c <= 21; c++) begin
      @(negedge clk);
      check_ref_cycle(c, 160'(0), res1);
    end

    // start pulsed during FEED is ignored: exactly one done, at cycle 20.
    pe_out = res2;
    done_cnt = 0; done_at = -1;
    pulse_start();
    for (int c = 0; c <= 44; c++) begin
      @(negedge clk);
      if (c == 6) start = 1'b1;
      if (c == 7) begin
        start = 1'b0;
        check_val("feed_start_state", 160'(dbg_state), 160'(FEED));
        check_val("feed_start_control", 160'(control), 160'(0));
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
    end
    check_val("feed_start_done_count", 160'(done_cnt), 160'(1));
    check_val("feed_start_done_cycle", 160'(done_at), 160'(20));
    check_val("feed_start_result", 160'(result), res2);

    // Reset in FEED cycle 7 abandons the job.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pe_out = res3;
    done_cnt = 0;
    pulse_start();
    for (int c = 0; c <= 7; c++) @(negedge clk);
    check_val("abort_pre_state", 160'(dbg_state), 160'(FEED));
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort");
    rst = 1'b0;
    for (int c = 9; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check_val("abort_done_count", 160'(done_cnt), 160'(0));
    check_val("abort_result", 160'(result), 160'(0));
    check_val("abort_busy", 160'(busy), 160'(0));

    // start held high: done at cycles 20 and 42, one IDLE cycle between jobs.
    pe_out = res1;
    exp_q.push_back(32'd20);
    exp_q.push_back(32'd42);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() > 0) check_val($sformatf("held_done_c%0d", c), 160'(c), 160'(exp_q.pop_front()));
        else check_val($sformatf("held_extra_done_c%0d", c), 160'(done), 160'(0));
      end
      if (c == 21) begin
        check_val("held_gap_state", 160'(dbg_state), 160'(IDLE));
        check_val("held_gap_busy", 160'(busy), 160'(0));
      end
      if (c == 22) begin
        check_val("held_restart_state", 160'(dbg_state), 160'(LOAD_WT));
        check_val("held_restart_control", 160'(control), 160'(1));
      end
    end
    start = 1'b0;
    check_val("held_missing_dones", 160'(exp_q.size()), 160'(0));
    check_val("held_result", 160'(result), res1);

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // ---------------------------------------------------------------- report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
